// File: rtl/wb_result_checker.sv
// In-circuit result checker for the pipelined MIPS core: shadows writeback traffic
// during a bounded run, then scans the shadow against a loadable expected table.
module wb_result_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int CNT_W        = 16,
  parameter int CYCLE_LIMIT  = 90,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_halt,
  input  logic                  i_wb_reg_write,
  input  logic [ADDR_W-1:0]     i_wb_write_register,
  input  logic [DATA_WIDTH-1:0] i_wb_write_data,
  input  logic                  i_cfg_we,
  input  logic [ADDR_W-1:0]     i_cfg_idx,
  input  logic [DATA_WIDTH-1:0] i_cfg_value,
  input  logic                  i_cfg_check_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [ADDR_W:0]       o_fail_count,
  output logic [ADDR_W-1:0]     o_first_fail_idx,
  output logic [DATA_WIDTH-1:0] o_first_fail_value,
  output logic [CNT_W-1:0]      o_cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);
  localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CHECK, DONE} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] shadow   [NUM_REGS];
  logic [DATA_WIDTH-1:0] expected [NUM_REGS];
  logic [NUM_REGS-1:0]   check_en;

  logic [ADDR_W-1:0] scan_idx;
  logic [DW-1:0]     drain_cnt;

  logic idle_or_done;
  logic start_ok;
  logic cfg_ok;
  logic capture;
  logic limit_hit;
  logic drain_last;
  logic scan_last;
  logic mismatch;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start_ok     = idle_or_done && i_start;
  assign cfg_ok       = idle_or_done && i_cfg_we && ({1'b0, i_cfg_idx} < NUM_REGS_EXT);
  assign capture      = ((state == RUN) || (state == DRAIN)) && i_wb_reg_write &&
                        (i_wb_write_register != '0) &&
                        ({1'b0, i_wb_write_register} < NUM_REGS_EXT);
  assign limit_hit    = (o_cycle_count == LIMIT_LAST);
  assign drain_last   = (drain_cnt == DRAIN_LAST);
  assign scan_last    = (scan_idx == SCAN_LAST);
  assign mismatch     = check_en[scan_idx] && (shadow[scan_idx] != expected[scan_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Halt takes priority over the cycle limit, so a halt on the final cycle is not a timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: if (i_start) next_state = RUN;
      RUN: begin
        if (i_halt)         next_state = (DRAIN_CYCLES == 0) ? CHECK : DRAIN;
        else if (limit_hit) next_state = CHECK;
      end
      DRAIN: if (drain_last) next_state = CHECK;
      CHECK: if (scan_last)  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (state)
      RUN, DRAIN, CHECK: o_busy = 1'b1;
      DONE:              o_done = 1'b1;
      default: ;
    endcase
    o_pass = o_done && (o_fail_count == '0) && !o_timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (capture) begin
      shadow[i_wb_write_register] <= i_wb_write_data;
    end
  end

  // The table survives restarts; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) expected[i] <= '0;
      check_en <= '0;
    end else if (cfg_ok) begin
      expected[i_cfg_idx] <= i_cfg_value;
      check_en[i_cfg_idx] <= i_cfg_check_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_timeout          <= 1'b0;
      o_fail_count       <= '0;
      o_first_fail_idx   <= '0;
      o_first_fail_value <= '0;
      o_cycle_count      <= '0;
      scan_idx           <= '0;
      drain_cnt          <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (i_start) begin
            o_timeout          <= 1'b0;
            o_fail_count       <= '0;
            o_first_fail_idx   <= '0;
            o_first_fail_value <= '0;
            o_cycle_count      <= '0;
            scan_idx           <= '0;
            drain_cnt          <= '0;
          end
        end
        RUN: begin
          if (o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
          if (!i_halt && limit_hit) o_timeout <= 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        CHECK: begin
          scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
          if (mismatch) begin
            o_fail_count <= o_fail_count + 1'b1;
            if (o_fail_count == '0) begin
              o_first_fail_idx   <= scan_idx;
              o_first_fail_value <= shadow[scan_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wb_result_checker.md
Name: wb_result_checker

Overview:
- Synthesizable, parametrised in-circuit result checker for the pipelined MIPS core.
- Snoops the writeback port into a shadow register file and bounds the run with a halt/cycle-limit window.
- After the run it compares the shadow against a loadable expected-value table and reports pass/fail, mismatch count and the first mismatch.
- Sits beside the core top level, wired to the WB-stage outputs and the halt line. Allows self-checking on FPGA without a simulator.

Parameters:
DATA_WIDTH, 32, width of register data
NUM_REGS, 32, number of architectural registers checked
ADDR_W, 5, register index width (clog2 of NUM_REGS)
CNT_W, 16, cycle counter width
CYCLE_LIMIT, 90, RUN cycles before timeout
DRAIN_CYCLES, 4, cycles of WB capture after halt (pipeline drain); 0 allowed

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_start  in  1  begin run; honoured only in IDLE or DONE
i_halt  in  1  core halt indication
i_wb_reg_write  in  1  WB register write enable
i_wb_write_register  in  ADDR_W  WB destination index
i_wb_write_data  in  DATA_WIDTH  WB data
i_cfg_we  in  1  write expected-table entry; honoured only in IDLE or DONE
i_cfg_idx  in  ADDR_W  entry index
i_cfg_value  in  DATA_WIDTH  expected value
i_cfg_check_en  in  1  1 = entry checked, 0 = don't care
o_busy  out  1  high in RUN, DRAIN, CHECK
o_done  out  1  high in DONE
o_pass  out  1  done and zero mismatches and no timeout
o_timeout  out  1  CYCLE_LIMIT reached without halt
o_fail_count  out  ADDR_W+1  number of mismatching checked entries
o_first_fail_idx  out  ADDR_W  lowest mismatching index
o_first_fail_value  out  DATA_WIDTH  shadow value at that index
o_cycle_count  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; shadow file all 0; expected table values 0 with all check_en 0.
- States: IDLE, RUN, DRAIN, CHECK, DONE.
- IDLE/DONE -> RUN on i_start.
  - Clears the shadow file, cycle counter, timeout, fail_count, first_fail_* and the done/pass outputs.
  - The expected table is retained.
- RUN:
  - Cycle counter increments each cycle and saturates at all-ones.
  - WB captured: if i_wb_reg_write and index != 0, shadow[index] <= data. Writes to index 0 are ignored, so shadow[0] stays 0.
  - i_halt high -> DRAIN, or CHECK if DRAIN_CYCLES = 0. A WB write in the same cycle as the halt is still captured.
  - Counter reaching CYCLE_LIMIT-1 with no halt -> o_timeout <= 1 and go to CHECK; there is no drain on timeout.
  - Halt and limit in the same cycle: halt wins and o_timeout stays 0.
- DRAIN: exactly DRAIN_CYCLES cycles. WB capture continues, i_halt is ignored, then -> CHECK.
- CHECK:
  - Scan pointer runs 0..NUM_REGS-1, one entry per cycle. WB is ignored.
  - Mismatch = check_en[i] && shadow[i] != expected[i]. On a mismatch: fail_count++.
  - On the first mismatch only: first_fail_idx <= i, first_fail_value <= shadow[i].
  - After index NUM_REGS-1 -> DONE.
- DONE:
  - o_done = 1; o_pass = (fail_count == 0) && !o_timeout.
  - All results are held until i_start or reset.
- Latency from halt sampled to o_done: DRAIN_CYCLES + NUM_REGS cycles.
- i_start is ignored in RUN, DRAIN and CHECK. i_cfg_we is ignored in those states.
- i_cfg_we and i_start together in IDLE: the table write occurs and the run starts, so the written entry is used.
- Comparison is bit-exact, so signed values need no special handling (e.g. -31 = 0xFFFFFFE1).
- Reset asserted mid-operation: immediate return to reset values, including a cleared expected table.

Test Plan:
- Match: load expected $3=0, $4=30, $6=0xFFFFFFE1, $10=30 (check_en=1), start, drive those 4 WB writes, halt at cycle 20 -> o_done after 4+32 cycles, o_pass=1, o_fail_count=0, o_cycle_count=20.
- Mismatch: expected $5=30, $9=5; WB writes $5=31, $9=4, halt -> o_pass=0, o_fail_count=2, o_first_fail_idx=5, o_first_fail_value=31.
- Zero/don't-care: expected $0=0 enabled, $14 disabled; WB writes $0=7 and $14=99 -> o_pass=1.
- Drain: DRAIN_CYCLES=4; halt, then WB $11=10 two cycles later with expected $11=10 -> pass. Repeat with the write 5 cycles after halt -> fail, o_first_fail_idx=11.
- Timeout: CYCLE_LIMIT=90, no halt -> o_timeout=1, o_cycle_count=90, o_pass=0 with no mismatches. Halt and limit in the same cycle -> o_timeout=0.
- Reset/restart: assert reset mid-CHECK -> all outputs 0, state IDLE. Separately, i_start in DONE -> results cleared, table retained, second run passes.
